testdrive_axi4_slave_mem_bfm: RTL and testbench

//  Parametrised AXI4 slave memory model: answers AXI4 bursts from an internal word array, no DPI/host bridge.

---
 rtl/testdrive_axi4_slave_mem_bfm_if.sv | 60 ++++++
 rtl/testdrive_axi4_slave_mem_bfm.sv | 237 +++++++++++++++++++++++
 tb/tb_testdrive_axi4_slave_mem_bfm.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/testdrive_axi4_slave_mem_bfm_if.sv
// AXI4 bus bundle between a master (testbench/initiator) and the slave memory model.
interface testdrive_axi4_slave_mem_bfm_if #(
    parameter int C_THREAD_ID_WIDTH = 1,
    parameter int C_ADDR_WIDTH      = 32,
    parameter int C_DATA_WIDTH      = 128
);
    logic [C_THREAD_ID_WIDTH-1:0] AWID;
    logic [C_ADDR_WIDTH-1:0]      AWADDR;
    logic [7:0]                   AWLEN;
    logic [1:0]                   AWBURST;
    logic                         AWVALID;
    logic                         AWREADY;
    logic [C_DATA_WIDTH-1:0]      WDATA;
    logic [C_DATA_WIDTH/8-1:0]    WSTRB;
    logic                         WLAST;
    logic                         WVALID;
    logic                         WREADY;
    logic [C_THREAD_ID_WIDTH-1:0] BID;
    logic [1:0]                   BRESP;
    logic                         BVALID;
    logic                         BREADY;
    logic [C_THREAD_ID_WIDTH-1:0] ARID;
    logic [C_ADDR_WIDTH-1:0]      ARADDR;
    logic [7:0]                   ARLEN;
    logic [1:0]                   ARBURST;
    logic                         ARVALID;
    logic                         ARREADY;
    logic [C_THREAD_ID_WIDTH-1:0] RID;
    logic [C_DATA_WIDTH-1:0]      RDATA;
    logic [1:0]                   RRESP;
    logic                         RLAST;
    logic                         RVALID;
    logic                         RREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );
endinterface

// File: rtl/testdrive_axi4_slave_mem_bfm.sv
// AXI4 slave memory model with FIXED/INCR/WRAP bursts, byte strobes, read latency and SLVERR.
// Optional random backpressure: define TESTDRIVE_AXI_BACKPRESSURE_EN.
module testdrive_axi4_slave_mem_bfm #(
    parameter int C_THREAD_ID_WIDTH = 1,
    parameter int C_ADDR_WIDTH      = 32,
    parameter int C_DATA_WIDTH      = 128,
    parameter int C_MEM_DEPTH_LOG2  = 10,
    parameter int C_READ_LATENCY    = 2
) (
    input logic CLK,
    input logic RST,
    testdrive_axi4_slave_mem_bfm_if.slave axi
);
    localparam int NB        = C_DATA_WIDTH / 8;
    localparam int OFFS      = $clog2(NB);
    localparam int IDXW      = C_ADDR_WIDTH - OFFS;
    localparam int MEM_WORDS = 2 ** C_MEM_DEPTH_LOG2;

    typedef logic [IDXW-1:0] idx_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    function automatic logic wrap_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic burst_bad(input logic [1:0] burst, input logic [7:0] len);
        return (burst == 2'b11) || ((burst == 2'b10) && !wrap_ok(len));
    endfunction

    function automatic logic in_range(input idx_t idx);
        return (idx >> C_MEM_DEPTH_LOG2) == '0;
    endfunction

    // Illegal WRAP lengths and the reserved encoding fall back to INCR stepping.
    function automatic idx_t next_idx(input idx_t idx, input logic [1:0] burst, input logic [7:0] len);
        idx_t mask;
        idx_t res;
        mask = idx_t'(len);
        res  = idx + idx_t'(1);
        if (burst == 2'b00)
            res = idx;
        else if ((burst == 2'b10) && wrap_ok(len))
            res = (idx & ~mask) | ((idx + idx_t'(1)) & mask);
        return res;
    endfunction

    logic [C_DATA_WIDTH-1:0] mem [MEM_WORDS];

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic run, stall, bvalid, rvalid;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    logic [C_THREAD_ID_WIDTH-1:0] w_id;
    idx_t                         w_idx;
    logic [7:0]                   w_len, w_cnt;
    logic [1:0]                   w_burst;
    logic                         w_past, w_err, wr_en;

    logic [C_THREAD_ID_WIDTH-1:0] rid_q;
    idx_t                         r_idx, ld_idx;
    logic [7:0]                   r_len, r_beat, ld_beat;
    logic [1:0]                   r_burst, rresp_q;
    logic [3:0]                   r_lat;
    logic                         r_bad, rlast_q, ld_en;
    logic [C_DATA_WIDTH-1:0]      rdata_q;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{axi.AWADDR[OFFS-1:0], axi.ARADDR[OFFS-1:0]};

    // Holds every READY low while reset is asserted and for nothing longer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) run <= 1'b0;
        else     run <= 1'b1;
    end

`ifdef TESTDRIVE_AXI_BACKPRESSURE_EN
    logic [15:0] lfsr;
    logic        b_shown, r_shown;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lfsr    <= 16'hACE1;
            b_shown <= 1'b0;
            r_shown <= 1'b0;
        end else begin
            lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            b_shown <= bvalid && !axi.BREADY;
            r_shown <= rvalid && !axi.RREADY;
        end
    end

    // A VALID already on the bus stays up regardless of the stall bit.
    assign stall  = lfsr[0];
    assign bvalid = (w_state == W_RESP) && (b_shown || !stall);
    assign rvalid = (r_state == R_DATA) && (r_shown || !stall);
`else
    assign stall  = 1'b0;
    assign bvalid = (w_state == W_RESP);
    assign rvalid = (r_state == R_DATA);
`endif

    assign axi.AWREADY = run && !stall && (w_state == W_IDLE);
    assign axi.WREADY  = run && !stall && (w_state == W_DATA);
    assign axi.ARREADY = run && !stall && (r_state == R_IDLE);
    assign axi.BVALID  = bvalid;
    assign axi.BID     = w_id;
    assign axi.BRESP   = {w_err, 1'b0};
    assign axi.RVALID  = rvalid;
    assign axi.RID     = rid_q;
    assign axi.RDATA   = rdata_q;
    assign axi.RRESP   = rresp_q;
    assign axi.RLAST   = rlast_q;

    assign aw_hs = axi.AWVALID && axi.AWREADY;
    assign w_hs  = axi.WVALID && axi.WREADY;
    assign b_hs  = bvalid && axi.BREADY;
    assign ar_hs = axi.ARVALID && axi.ARREADY;
    assign r_hs  = rvalid && axi.RREADY;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && axi.WLAST) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Beats beyond AWLEN+1 or outside the array are accepted but dropped.
    assign wr_en = w_hs && !w_past && in_range(w_idx);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            w_id    <= '0;
            w_idx   <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_past  <= 1'b0;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            w_id    <= axi.AWID;
            w_idx   <= axi.AWADDR[C_ADDR_WIDTH-1:OFFS];
            w_len   <= axi.AWLEN;
            w_burst <= axi.AWBURST;
            w_cnt   <= '0;
            w_past  <= 1'b0;
            w_err   <= burst_bad(axi.AWBURST, axi.AWLEN);
        end else if (w_hs) begin
            w_idx <= next_idx(w_idx, w_burst, w_len);
            if (w_cnt == w_len) w_past <= 1'b1;
            else                w_cnt  <= w_cnt + 8'd1;
            w_err <= w_err
                   | (!w_past && !in_range(w_idx))
                   | (axi.WLAST && (w_past || (w_cnt != w_len)));
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en)
            for (int b = 0; b < NB; b++)
                if (axi.WSTRB[b])
                    mem[w_idx[C_MEM_DEPTH_LOG2-1:0]][8*b +: 8] <= axi.WDATA[8*b +: 8];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_WAIT;
            R_WAIT:  if (r_lat == '0) r_next = R_DATA;
            R_DATA:  if (r_hs && rlast_q) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // First beat loads as latency expires; later beats load on each accepted beat.
    always_comb begin
        ld_en   = 1'b0;
        ld_idx  = r_idx;
        ld_beat = r_beat;
        if ((r_state == R_WAIT) && (r_lat == '0)) begin
            ld_en = 1'b1;
        end else if (r_hs && !rlast_q) begin
            ld_en   = 1'b1;
            ld_idx  = next_idx(r_idx, r_burst, r_len);
            ld_beat = r_beat + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rid_q   <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_bad   <= 1'b0;
            r_beat  <= '0;
            r_lat   <= '0;
            rdata_q <= '0;
            rresp_q <= '0;
            rlast_q <= 1'b0;
        end else begin
            if (ar_hs) begin
                rid_q   <= axi.ARID;
                r_idx   <= axi.ARADDR[C_ADDR_WIDTH-1:OFFS];
                r_len   <= axi.ARLEN;
                r_burst <= axi.ARBURST;
                r_bad   <= burst_bad(axi.ARBURST, axi.ARLEN);
                r_beat  <= '0;
                r_lat   <= 4'(C_READ_LATENCY);
            end else if ((r_state == R_WAIT) && (r_lat != '0)) begin
                r_lat <= r_lat - 4'd1;
            end
            if (ld_en) begin
                r_idx   <= ld_idx;
                r_beat  <= ld_beat;
                rdata_q <= in_range(ld_idx) ? mem[ld_idx[C_MEM_DEPTH_LOG2-1:0]] : '0;
                rresp_q <= {r_bad || !in_range(ld_idx), 1'b0};
                rlast_q <= (ld_beat == r_len);
            end
        end
    end
endmodule

// File: tb/tb_testdrive_axi4_slave_mem_bfm.sv
// Directed bench for the AXI4 slave memory model (default build, read latency 2).
module tb_testdrive_axi4_slave_mem_bfm;
    localparam int IDW = 1;
    localparam int AW  = 32;
    localparam int DW  = 128;
    localparam int DL  = 10;
    localparam int LAT = 2;
    localparam int TMO = 50;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    testdrive_axi4_slave_mem_bfm_if #(
        .C_THREAD_ID_WIDTH(IDW), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)
    ) bus ();

    testdrive_axi4_slave_mem_bfm #(
        .C_THREAD_ID_WIDTH(IDW), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW),
        .C_MEM_DEPTH_LOG2(DL), .C_READ_LATENCY(LAT)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .axi(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] wd [16];
    logic [DW-1:0] rd [16];
    logic [1:0]    rr [16];
    logic          rl [16];
    int            rlat;
    logic [1:0]    bresp;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input int nbeats, input logic [DW/8-1:0] strb, output logic [1:0] resp);
        int t;
        bus.AWID = 1'b1; bus.AWADDR = addr; bus.AWLEN = len; bus.AWBURST = burst; bus.AWVALID = 1'b1;
        t = 0;
        while (!bus.AWREADY && t < TMO) begin tick(); t++; end
        check("aw_wait", 128'(t < TMO), 128'd1);
        tick();
        bus.AWVALID = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            bus.WDATA = wd[i]; bus.WSTRB = strb; bus.WLAST = (i == nbeats - 1); bus.WVALID = 1'b1;
            t = 0;
            while (!bus.WREADY && t < TMO) begin tick(); t++; end
            check("w_wait", 128'(t < TMO), 128'd1);
            tick();
        end
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;
        bus.BREADY = 1'b1;
        t = 0;
        while (!bus.BVALID && t < TMO) begin tick(); t++; end
        check("b_wait", 128'(t < TMO), 128'd1);
        check("bid", 128'(bus.BID), 128'd1);
        resp = bus.BRESP;
        tick();
        bus.BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input bit hold_first);
        int t;
        bus.ARID = 1'b1; bus.ARADDR = addr; bus.ARLEN = len; bus.ARBURST = burst; bus.ARVALID = 1'b1;
        bus.RREADY = !hold_first;
        t = 0;
        while (!bus.ARREADY && t < TMO) begin tick(); t++; end
        check("ar_wait", 128'(t < TMO), 128'd1);
        tick();
        bus.ARVALID = 1'b0;
        rlat = 0;
        while (!bus.RVALID && rlat < TMO) begin tick(); rlat++; end
        check("rid", 128'(bus.RID), 128'd1);
        for (int i = 0; i <= int'(len); i++) begin
            t = 0;
            while (!bus.RVALID && t < TMO) begin tick(); t++; end
            check("r_wait", 128'(t < TMO), 128'd1);
            if (hold_first && i == 0) begin
                tick();
                check("r_valid_held", 128'(bus.RVALID), 128'd1);
                bus.RREADY = 1'b1;
            end
            rd[i] = bus.RDATA; rr[i] = bus.RRESP; rl[i] = bus.RLAST;
            tick();
        end
        bus.RREADY = 1'b0;
    endtask

    initial begin
        int t;
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
        bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;
        RST = 1'b1;
        repeat (3) tick();
        check("rst_awready", 128'(bus.AWREADY), 128'd0);
        check("rst_arready", 128'(bus.ARREADY), 128'd0);
        check("rst_wready",  128'(bus.WREADY),  128'd0);
        check("rst_bvalid",  128'(bus.BVALID),  128'd0);
        check("rst_rvalid",  128'(bus.RVALID),  128'd0);
        check("rst_rlast",   128'(bus.RLAST),   128'd0);
        check("rst_rdata",   bus.RDATA,         128'd0);
        RST = 1'b0;
        tick();
        check("awready_after_rst", 128'(bus.AWREADY), 128'd1);

        // INCR write/read round trip with latency and RLAST checks
        wd[0] = 128'h11; wd[1] = 128'h22; wd[2] = 128'h33; wd[3] = 128'h44;
        axi_write(32'h100, 8'd3, 2'b01, 4, '1, bresp);
        check("t1_bresp", 128'(bresp), 128'd0);
        axi_read(32'h100, 8'd3, 2'b01, 1'b1);
        check("t1_latency", 128'(rlat), 128'(LAT + 1));
        for (int i = 0; i < 4; i++) begin
            check("t1_rdata", rd[i], 128'((i + 1) * 8'h11));
            check("t1_rresp", 128'(rr[i]), 128'd0);
            check("t1_rlast", 128'(rl[i]), 128'(i == 3));
        end

        // WRAP from word 6 fills 6,7,4,5
        wd[0] = 128'd1; wd[1] = 128'd2; wd[2] = 128'd3; wd[3] = 128'd4;
        axi_write(32'h60, 8'd3, 2'b10, 4, '1, bresp);
        check("t2_bresp", 128'(bresp), 128'd0);
        axi_read(32'h40, 8'd3, 2'b01, 1'b0);
        check("t2_w4", rd[0], 128'd3);
        check("t2_w5", rd[1], 128'd4);
        check("t2_w6", rd[2], 128'd1);
        check("t2_w7", rd[3], 128'd2);

        // FIXED read repeats the same word
        axi_read(32'h100, 8'd1, 2'b00, 1'b0);
        check("fixed_b0", rd[0], 128'h11);
        check("fixed_b1", rd[1], 128'h11);

        // Single-byte strobe
        wd[0] = '0;
        axi_write(32'h0, 8'd0, 2'b01, 1, '1, bresp);
        wd[0] = {{15{8'hAA}}, 8'hFF};
        axi_write(32'h0, 8'd0, 2'b01, 1, 16'h0001, bresp);
        check("t3_bresp", 128'(bresp), 128'd0);
        axi_read(32'h0, 8'd0, 2'b01, 1'b0);
        check("t3_rdata", rd[0], 128'hFF);

        // Out-of-range beat: aliasing word 0 must stay untouched
        wd[0] = '1;
        axi_write(32'h4000, 8'd0, 2'b01, 1, '1, bresp);
        check("t4_bresp", 128'(bresp), 128'd2);
        axi_read(32'h0, 8'd0, 2'b01, 1'b0);
        check("t4_word0", rd[0], 128'hFF);
        axi_read(32'h4000, 8'd0, 2'b01, 1'b0);
        check("t4_rdata", rd[0], 128'd0);
        check("t4_rresp", 128'(rr[0]), 128'd2);
        check("t4_rlast", 128'(rl[0]), 128'd1);

        // Reserved burst: INCR addressing but SLVERR
        wd[0] = 128'h55; wd[1] = 128'h66;
        axi_write(32'h200, 8'd1, 2'b11, 2, '1, bresp);
        check("rsvd_bresp", 128'(bresp), 128'd2);
        axi_read(32'h200, 8'd1, 2'b01, 1'b0);
        check("rsvd_w0", rd[0], 128'h55);
        check("rsvd_w1", rd[1], 128'h66);
        check("rsvd_rresp_ok", 128'(rr[1]), 128'd0);
        axi_read(32'h200, 8'd2, 2'b10, 1'b0);
        check("badwrap_rresp", 128'(rr[0]), 128'd2);
        check("badwrap_w1", rd[1], 128'h66);

        // Early WLAST
        wd[0] = 128'h77; wd[1] = 128'h88;
        axi_write(32'h300, 8'd3, 2'b01, 2, '1, bresp);
        check("early_wlast_bresp", 128'(bresp), 128'd2);

        // Reset while beat 2 of 4 is on the bus
        bus.ARID = 1'b0; bus.ARADDR = 32'h100; bus.ARLEN = 8'd3; bus.ARBURST = 2'b01;
        bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
        t = 0;
        while (!bus.ARREADY && t < TMO) begin tick(); t++; end
        tick();
        bus.ARVALID = 1'b0;
        t = 0;
        while (!bus.RVALID && t < TMO) begin tick(); t++; end
        check("t5_beat1", bus.RDATA, 128'h11);
        tick();
        check("t5_beat2", bus.RDATA, 128'h22);
        RST = 1'b1;
        #1;
        check("t5_rvalid_rst", 128'(bus.RVALID), 128'd0);
        check("t5_arready_rst", 128'(bus.ARREADY), 128'd0);
        bus.RREADY = 1'b0;
        tick();
        RST = 1'b0;
        tick();
        check("t5_arready_after", 128'(bus.ARREADY), 128'd1);
        axi_read(32'h100, 8'd3, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++)
            check("t5_rdata", rd[i], 128'((i + 1) * 8'h11));
        check("t5_rlast", 128'(rl[3]), 128'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end
endmodule
